// File: rtl/u_seqdiv8.sv
// Sequential restoring divider: one shift-subtract step per clock, WIDTH steps per
// division, results registered on entry to DONE and held until the next completion.
module u_seqdiv8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic               load_s;
  logic               step_s;
  logic               finish_s;
  logic               last_s;
  logic               busy_d_s;
  logic               done_d_s;

  logic [WIDTH-1:0]   dvd_r;
  logic [WIDTH-1:0]   dsr_r;
  logic [WIDTH-1:0]   rem_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   quotient_r;
  logic [WIDTH-1:0]   remainder_r;
  logic               dbz_r;

  logic [WIDTH:0]     shifted_s;
  logic [WIDTH:0]     trial_s;
  logic               q_bit_s;
  logic [WIDTH-1:0]   rem_next_s;
  logic [WIDTH-1:0]   quo_next_s;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = IDLE;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FSM output decode: datapath controls and next-cycle status flags
  always_comb begin
    last_s   = (cnt_r == LAST_CNT);
    load_s   = 1'b0;
    step_s   = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        load_s = start;
      end
      RUN: begin
        step_s   = 1'b1;
        finish_s = last_s;
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
    busy_d_s = (next_state_s == RUN);
    done_d_s = (next_state_s == DONE);
  end

  // One restoring step; the sign of the (WIDTH+1)-bit trial difference picks the quotient bit.
  // With divisor 0 the difference never goes negative, so the quotient fills with ones
  // and the partial remainder accumulates the dividend unchanged.
  always_comb begin
    shifted_s = {1'b0, rem_r[WIDTH-1:0]} << 1;
    shifted_s[0] = dvd_r[WIDTH-1];
    trial_s   = shifted_s - {1'b0, dsr_r};
    q_bit_s   = ~trial_s[WIDTH];
    if (q_bit_s) begin
      rem_next_s = trial_s[WIDTH-1:0];
    end else begin
      rem_next_s = shifted_s[WIDTH-1:0];
    end
    quo_next_s = {dvd_r[WIDTH-2:0], q_bit_s};
  end

  // Operand, partial-remainder, counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_r       <= '0;
      dsr_r       <= '0;
      rem_r       <= '0;
      cnt_r       <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
    end else begin
      busy_r <= busy_d_s;
      done_r <= done_d_s;
      if (load_s) begin
        dvd_r <= dividend;
        dsr_r <= divisor;
        rem_r <= '0;
        cnt_r <= '0;
      end else if (step_s) begin
        dvd_r <= quo_next_s;
        rem_r <= rem_next_s;
        cnt_r <= cnt_r + CNT_ONE;
      end
      if (finish_s) begin
        quotient_r  <= quo_next_s;
        remainder_r <= rem_next_s;
        dbz_r       <= (dsr_r == '0);
      end
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dbz_r;

endmodule
